// File: rtl/prog_loader_if.sv
// ============================================================================
// prog_loader_if : valid/ready instruction-word stream into the program loader
// Revision 1.0
// ============================================================================
`default_nettype none

interface prog_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : streams a program into instruction RAM, holds CPU reset, serves fetch
// Option macro PROG_LOADER_CHECKSUM_EN: trailing checksum word gates release. Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int          AW  = 5,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  prog_loader_if.slave  stream,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW + 1)'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd2;
  // After the last program word (or immediately for len==0) the checksum follows.
  localparam logic [2:0] S_AFTER = S_CHECK;
`else
  localparam logic [2:0] S_AFTER = S_RUN;
`endif

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [AW:0] addr;
  logic [AW:0] len;
  logic        xfer;
  logic        load_xfer;
  logic        start_ok;
  logic        busy_nx;
  logic [31:0] mem [DEPTH];
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

`ifdef PROG_LOADER_CHECKSUM_EN
  assign stream.in_ready = (state == S_LOAD) || (state == S_CHECK);
  assign busy_nx         = (state_nx == S_LOAD) || (state_nx == S_CHECK);
`else
  assign stream.in_ready = (state == S_LOAD);
  assign busy_nx         = (state_nx == S_LOAD);
`endif

  assign xfer      = stream.in_valid & stream.in_ready;
  assign load_xfer = xfer && (state == S_LOAD);
  assign start_ok  = load_start &&
                     ((state == S_IDLE) || (state == S_RUN) || (state == S_ERROR));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (load_start) begin
          if (load_len > DEPTH_L)
            state_nx = S_ERROR;
          else if (load_len == '0)
            state_nx = S_AFTER;
          else
            state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_xfer && ((addr + ONE) == len))
          state_nx = S_AFTER;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer)
          state_nx = (stream.in_data == sum) ? S_RUN : S_ERROR;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      len       <= '0;
      cpu_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      // Flags are decoded from the next state so they move on the same edge.
      state     <= state_nx;
      cpu_rst_n <= (state_nx == S_RUN);
      done      <= (state_nx == S_RUN);
      err       <= (state_nx == S_ERROR);
      busy      <= busy_nx;
      if (start_ok) begin
        len  <= load_len;
        addr <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum  <= '0;
`endif
      end else if (load_xfer) begin
        addr <= addr + ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum  <= sum + stream.in_data;
`endif
      end
    end
  end

  // RAM is deliberately not reset so a partial program survives an abort.
  always_ff @(posedge clk) begin
    if (load_xfer)
      mem[addr[AW-1:0]] <= stream.in_data;
  end

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pc[1:0];

  assign instr = (pc[31:AW+2] != '0) ? NOP : mem[pc[AW+1:2]];

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : randomized self-checking bench with a word-array reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;
  localparam int          AW    = 5;
  localparam int          DEPTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0000;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_start;
  logic [AW:0] load_len;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        cpu_rst_n, busy, done, err;

  prog_loader_if sif ();

  prog_loader #(.AW(AW), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
    .stream(sif), .pc(pc), .instr(instr), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  logic [31:0] wbuf      [DEPTH];

  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    logic [31:0] w;
    w = a / 32'd4;
    if (w < DEPTH) return ref_mem[w];
    return NOP;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one load (start pulse, words, optional checksum) and records observations.
  task automatic run_load(input int len, input int mode, input logic [31:0] mask,
                          input bit bad, output int ticks, output int busy_obs,
                          output int early, output bit tmo);
    int idx;
    bit v;
    logic [31:0] cs;
    load_len   = (AW + 1)'(len);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    busy_obs = int'(busy);
    early    = (len > 0 || CSUM == 1) ? int'(cpu_rst_n | done) : 0;
    ticks = 0; idx = 0; tmo = 1'b0; cs = 32'h0;
    while (idx < len && !tmo) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? mask[ticks % 32] : 1'($urandom_range(0, 1));
      sif.in_valid = v;
      sif.in_data  = v ? wbuf[idx] : $urandom();
      tick;
      ticks++;
      if (v) begin
        ref_mem[idx]   = wbuf[idx];
        ref_known[idx] = 1'b1;
        cs  = cs + wbuf[idx];
        idx++;
      end
      busy_obs += int'(busy);
      if (idx < len || CSUM == 1) early += int'(cpu_rst_n | done);
      if (ticks > 400) tmo = 1'b1;
    end
    if (CSUM == 1) begin
      sif.in_valid = 1'b1;
      sif.in_data  = cs + (bad ? 32'd1 : 32'd0);
      tick;
      busy_obs += int'(busy);
    end
    sif.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    load_start = 1'b0; load_len = '0; pc = '0;
    sif.in_valid = 1'b0; sif.in_data = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n got %b want 0", cpu_rst_n); end
    checks++; if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", sif.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    repeat (2) tick;
    #3 rst_n = 1'b1;
    tick;
    checks++; if ({busy, done, err, cpu_rst_n} !== 4'b0000) begin errors++; $display("FAIL idle_after_reset got %b want 0000", {busy, done, err, cpu_rst_n}); end
  endtask

  task automatic test_len_error;
    int t, b, e; bit tmo;
    load_len = (AW + 1)'(DEPTH + 1); load_start = 1'b1;
    tick;
    load_start = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL len_err_err got %b want 1", err); end
    checks++; if ({cpu_rst_n, busy, done, sif.in_ready} !== 4'b0000) begin errors++; $display("FAIL len_err_flags got %b want 0000", {cpu_rst_n, busy, done, sif.in_ready}); end
    tick;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL len_err_hold got %b want 1", err); end
    wbuf[0] = $urandom();
    run_load(1, 0, 32'h0, 1'b0, t, b, e, tmo);
    checks++; if ({done, cpu_rst_n, err} !== 3'b110) begin errors++; $display("FAIL err_exit_flags got %b want 110", {done, cpu_rst_n, err}); end
    checks++; if (e !== 0) begin errors++; $display("FAIL err_exit_early got %0d want 0", e); end
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom();
    run_load(DEPTH, 2, 32'h0, 1'b0, t, b, e, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL full_timeout got %b want 0", tmo); end
    checks++; if (b !== t + CSUM) begin errors++; $display("FAIL full_busy_cycles got %0d want %0d", b, t + CSUM); end
    checks++; if ({done, cpu_rst_n, err, e} !== {3'b110, 32'd0}) begin errors++; $display("FAIL full_release got %b early %0d want 110 early 0", {done, cpu_rst_n, err}, e); end
    for (int i = 0; i < DEPTH; i++) begin
      pc = 32'(i * 4) + $urandom_range(0, 3);
      #1;
      checks++; if (instr !== ref_fetch(pc)) begin errors++; $display("FAIL full_ram pc=%h got %h want %h", pc, instr, ref_fetch(pc)); end
    end
    pc = 32'd124; #1;
    checks++; if (instr !== wbuf[31]) begin errors++; $display("FAIL full_pc124 got %h want %h", instr, wbuf[31]); end
  endtask

  task automatic test_back_to_back;
    int t, b, e; bit tmo;
    logic [31:0] old3;
    old3 = ref_mem[3];
    wbuf[0] = 32'h2402_0005; wbuf[1] = 32'h2403_0007; wbuf[2] = 32'h0062_1020;
    run_load(3, 0, 32'h0, 1'b0, t, b, e, tmo);
    checks++; if (t !== 3 || b !== 3 + CSUM) begin errors++; $display("FAIL b2b_busy ticks %0d busy %0d want 3 and %0d", t, b, 3 + CSUM); end
    checks++; if ({done, cpu_rst_n, e} !== {2'b11, 32'd0}) begin errors++; $display("FAIL b2b_release got %b early %0d want 11 early 0", {done, cpu_rst_n}, e); end
    pc = 32'd8; #1;
    checks++; if (instr !== 32'h0062_1020) begin errors++; $display("FAIL b2b_pc8 got %h want 00621020", instr); end
    pc = 32'd9; #1;
    checks++; if (instr !== 32'h0062_1020) begin errors++; $display("FAIL b2b_pc9 got %h want 00621020", instr); end
    pc = 32'h80; #1;
    checks++; if (instr !== NOP) begin errors++; $display("FAIL b2b_pc80 got %h want %h", instr, NOP); end
    pc = 32'd12; #1;
    checks++; if (instr !== old3) begin errors++; $display("FAIL b2b_word3_kept got %h want %h", instr, old3); end
  endtask

  task automatic test_valid_gaps;
    int t, b, e; bit tmo;
    logic [31:0] old3;
    old3 = ref_mem[3];
    wbuf[0] = 32'h2402_0005; wbuf[1] = 32'h2403_0007; wbuf[2] = 32'h0062_1020;
    run_load(3, 1, 32'b10_1001, 1'b0, t, b, e, tmo);
    checks++; if (t !== 6 || b !== 6 + CSUM) begin errors++; $display("FAIL gaps_busy ticks %0d busy %0d want 6 and %0d", t, b, 6 + CSUM); end
    checks++; if ({done, cpu_rst_n, e} !== {2'b11, 32'd0}) begin errors++; $display("FAIL gaps_release got %b early %0d want 11 early 0", {done, cpu_rst_n}, e); end
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4); #1;
      checks++; if (instr !== ((i == 3) ? old3 : wbuf[i])) begin errors++; $display("FAIL gaps_ram idx %0d got %h want %h", i, instr, (i == 3) ? old3 : wbuf[i]); end
    end
  endtask

  task automatic test_reload_from_run;
    int t, b, e; bit tmo;
    logic [31:0] old0;
    old0 = ref_mem[0];
    sif.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sif.in_data = $urandom();
      tick;
      checks++; if (sif.in_ready !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL run_no_accept ready %b done %b want 0 1", sif.in_ready, done); end
    end
    pc = 32'd0; #1;
    checks++; if (instr !== old0) begin errors++; $display("FAIL run_ram_kept got %h want %h", instr, old0); end
    wbuf[0] = 32'h0000_000C;
    run_load(1, 0, 32'h0, 1'b0, t, b, e, tmo);
    checks++; if (e !== 0) begin errors++; $display("FAIL reload_cpu_rst_drop early %0d want 0", e); end
    checks++; if ({done, cpu_rst_n} !== 2'b11) begin errors++; $display("FAIL reload_release got %b want 11", {done, cpu_rst_n}); end
    pc = 32'd0; #1;
    checks++; if (instr !== 32'h0000_000C) begin errors++; $display("FAIL reload_word got %h want 0000000c", instr); end
  endtask

  task automatic test_zero_len;
    int t, b, e; bit tmo;
    run_load(0, 0, 32'h0, 1'b0, t, b, e, tmo);
    checks++; if ({done, cpu_rst_n, err, busy} !== 4'b1100) begin errors++; $display("FAIL zero_len_flags got %b want 1100", {done, cpu_rst_n, err, busy}); end
    checks++; if (b !== CSUM) begin errors++; $display("FAIL zero_len_busy got %0d want %0d", b, CSUM); end
  endtask

  task automatic test_random_loads;
    int t, b, e, len; bit tmo, bad;
    logic [31:0] nxt;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, DEPTH);
      bad = (CSUM == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      nxt = (len < DEPTH) ? ref_mem[len % DEPTH] : 32'h0;
      for (int i = 0; i < len; i++) wbuf[i] = $urandom();
      run_load(len, 2, 32'h0, bad, t, b, e, tmo);
      checks++; if (tmo !== 1'b0 || b !== t + CSUM || e !== 0) begin errors++; $display("FAIL rand_seq tmo %b busy %0d early %0d want 0 %0d 0", tmo, b, e, t + CSUM); end
      checks++; if ({done, cpu_rst_n, err} !== (bad ? 3'b001 : 3'b110)) begin errors++; $display("FAIL rand_flags len %0d got %b want %b", len, {done, cpu_rst_n, err}, bad ? 3'b001 : 3'b110); end
      for (int i = 0; i < len; i++) begin
        pc = 32'(i * 4) + $urandom_range(0, 3); #1;
        checks++; if (instr !== ref_fetch(pc)) begin errors++; $display("FAIL rand_ram pc=%h got %h want %h", pc, instr, ref_fetch(pc)); end
      end
      if (len < DEPTH && ref_known[len]) begin
        pc = 32'(len * 4); #1;
        checks++; if (instr !== nxt) begin errors++; $display("FAIL rand_past_end pc=%h got %h want %h", pc, instr, nxt); end
      end
      pc = $urandom() | 32'h80; #1;
      checks++; if (instr !== ref_fetch(pc)) begin errors++; $display("FAIL rand_oob pc=%h got %h want %h", pc, instr, ref_fetch(pc)); end
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int t, b, e; bit tmo;
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    run_load(2, 0, 32'h0, 1'b0, t, b, e, tmo);
    checks++; if ({done, cpu_rst_n, err} !== 3'b110) begin errors++; $display("FAIL csum_good got %b want 110", {done, cpu_rst_n, err}); end
    wbuf[0] = $urandom(); wbuf[1] = $urandom();
    run_load(2, 0, 32'h0, 1'b1, t, b, e, tmo);
    checks++; if ({done, cpu_rst_n, err} !== 3'b001) begin errors++; $display("FAIL csum_bad got %b want 001", {done, cpu_rst_n, err}); end
    for (int i = 0; i < 2; i++) begin
      pc = 32'(i * 4); #1;
      checks++; if (instr !== wbuf[i]) begin errors++; $display("FAIL csum_ram idx %0d got %h want %h", i, instr, wbuf[i]); end
    end
  endtask
`endif

  task automatic test_reset_mid_load;
    logic [31:0] old2;
    old2 = ref_mem[2];
    for (int i = 0; i < 2; i++) wbuf[i] = $urandom();
    load_len = (AW + 1)'(4); load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sif.in_valid = 1'b1; sif.in_data = wbuf[i];
      tick;
      pc = 32'(i * 4); #1;
      checks++; if (instr !== wbuf[i]) begin errors++; $display("FAIL load_visible idx %0d got %h want %h", i, instr, wbuf[i]); end
    end
    sif.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busy, sif.in_ready, cpu_rst_n, done} !== 4'b0000) begin errors++; $display("FAIL midreset_async got %b want 0000", {busy, sif.in_ready, cpu_rst_n, done}); end
    tick;
    #2 rst_n = 1'b1;
    tick;
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL midreset_idle got %b want 000", {busy, done, err}); end
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4); #1;
      checks++; if (instr !== ((i == 2) ? old2 : wbuf[i])) begin errors++; $display("FAIL midreset_ram idx %0d got %h want %h", i, instr, (i == 2) ? old2 : wbuf[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = 32'h0; ref_known[i] = 1'b0; end
    test_reset;
    test_len_error;
    test_back_to_back;
    test_valid_gaps;
    test_reload_from_run;
    test_zero_len;
    test_random_loads;
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum;
`endif
    test_reset_mid_load;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
